pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the 3-stage RV32I core (IF, ID, EX). It arbitrates the redirect and hold requests coming from the execute stage and the memory bus, and turns them into PC redirect, stall and flush controls for the PC register and the if_id / id_ex pipeline registers. An optional halt/resume state machine drains the pipeline on an external halt request and replays a pending jump on resume.

## Interface
Parameters:
- DRAIN_CYCLES, default 2: cycles needed to retire in-flight instructions after fetch stops. Range 1..15.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- jump_en_i  input  1  EX requests a redirect.
- jump_addr_i  input  32  EX redirect target.
- hold_ex_i  input  1  EX is not finished; the instruction in EX must stay there.
- hold_mem_i  input  1  memory bus wait.
- halt_req_i  input  1  level; request to halt the core.
- resume_req_i  input  1  level; request to leave the halted state.
- jump_en_o  output  1  PC redirect strobe.
- jump_addr_o  output  32  PC redirect target.
- stall_pc_o  output  1  hold the PC.
- stall_if_id_o  output  1  hold if_id.
- stall_id_ex_o  output  1  hold id_ex.
- flush_if_id_o  output  1  load a NOP bubble into if_id.
- flush_id_ex_o  output  1  load a NOP bubble into id_ex.
- halted_o  output  1  core is halted; the pipeline is empty.

## Operation
Priority in state RUN, evaluated combinationally each cycle:
1. If hold_mem_i=1 or hold_ex_i=1:
   - stall_pc_o, stall_if_id_o and stall_id_ex_o are asserted.
   - jump_en_i is ignored. EX re-presents the jump when the hold releases.
2. Else if jump_en_i=1:
   - jump_en_o=1 and jump_addr_o=jump_addr_i.
   - flush_if_id_o=1 and flush_id_ex_o=1.
3. Else all controls are 0.

Outside a redirect, jump_addr_o is 0.

Halt FSM (states RUN, DRAIN, HALTED, RESUME; state register and 4-bit drain counter):
- **RUN, halt_req_i=1:** go to DRAIN and load the counter with DRAIN_CYCLES. The RUN controls for that same cycle still apply, so a simultaneous jump is honoured.
- **DRAIN:**
  - stall_pc_o=1 and flush_if_id_o=1, so no new instructions enter. id_ex and EX keep advancing.
  - The counter decrements only in cycles where hold_mem_i=0 and hold_ex_i=0. Holds also stall id_ex as in RUN.
  - A jump_en_i with no hold is not output. Instead, jump_addr_i is latched into pend_addr, pend_vld is set, and flush_id_ex_o=1.
  - When the counter is 1 and no hold is active, go to HALTED.
  - halt_req_i dropping during DRAIN has no effect; the drain completes.
- **HALTED:**
  - halted_o=1 and stall_pc_o=1.
  - flush_if_id_o=1 and flush_id_ex_o=1, so EX sees NOPs.
  - Hold and jump inputs are ignored.
  - resume_req_i=1 goes to RESUME.
- **RESUME:** one cycle.
  - All stalls and flushes are 0.
  - If pend_vld=1: jump_en_o=1, jump_addr_o=pend_addr, and pend_vld is cleared.
  - Always go to RUN.
  - halt_req_i is sampled again in RUN only, so a held request causes a re-halt from the next cycle.

Reset (asynchronous, including mid-drain or while halted):
- Returns to RUN with counter=0, pend_vld=0 and pend_addr=0.
- Outputs settle to the RUN combinational values, so halted_o=0 and no redirect.

## Timing
- RUN redirect, stall and flush: 0-cycle, combinational from the inputs.
- Halt latency: halt_req_i is sampled at edge N, giving DRAIN at N. halted_o rises at edge N+DRAIN_CYCLES when there are no hold cycles; each hold cycle adds 1.
- Resume: resume_req_i is sampled at an edge while HALTED, and the next cycle is RESUME. Any pending redirect is issued in that RESUME cycle, and RUN follows.
- All registered outputs and state are updated on the rising clk edge. There are no multicycle paths.

## Configuration
- Macro: PIPE_CTRL_HALT_EN.
- Defined: the FSM, counter, pend_addr and pend_vld are built as described.
- Undefined:
  - No state registers; the block is the RUN priority logic only.
  - halt_req_i and resume_req_i are ignored and halted_o is tied to 0.
  - clk and rst_n remain as ports and are unused.

## Structure
- Shared package / defines.v:
  - FSM state encoding as 2-bit constants CTRL_RUN=0, CTRL_DRAIN=1, CTRL_HALTED=2, CTRL_RESUME=3.
  - The NOP instruction constant (32'h00000013) used by the pipeline registers on flush.
- No sub-module: the FSM and priority mux form a single module.

## Test plan
1. **Jump in RUN:** jump_en_i=1, jump_addr_i=0x100, no holds → same cycle jump_en_o=1, jump_addr_o=0x100, both flushes=1.
2. **Jump with hold:** jump_en_i=1 with hold_mem_i=1 → jump_en_o=0, all three stalls=1. Drop the hold → jump issued that cycle.
3. **Halt drain:** DRAIN_CYCLES=2, pulse halt_req_i, no holds → halted_o=1 two edges later. With one hold cycle inserted → three edges later.
4. **Jump during drain:** jump_en_i=1 to 0x80 in DRAIN → jump_en_o=0, then HALTED. resume_req_i=1 → in the RESUME cycle jump_en_o=1 and jump_addr_o=0x80. The following cycle is RUN with no redirect.
5. **Reset while HALTED:** rst_n low asynchronously → halted_o=0 immediately. After release, RUN; resume_req_i has no effect; no pending redirect.
6. **Macro undefined:** halt_req_i=1 held for 10 cycles → halted_o stays 0 and RUN redirect, stall and flush behaviour is unchanged.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: halt FSM encoding and the flush bubble.
// Imported by the pipe_ctrl interface and top.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN    = 2'd0,
    CTRL_DRAIN  = 2'd1,
    CTRL_HALTED = 2'd2,
    CTRL_RESUME = 2'd3
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl request/control bundle.
// master drives requests, slave is the control unit.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_mem_i;
  logic        halt_req_i;
  logic        resume_req_i;

  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o;
  logic        stall_if_id_o;
  logic        stall_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        halted_o;

  modport master (
    output jump_en_i, jump_addr_i,
    output hold_ex_i, hold_mem_i,
    output halt_req_i, resume_req_i,
    input  jump_en_o, jump_addr_o,
    input  stall_pc_o, stall_if_id_o,
    input  stall_id_ex_o,
    input  flush_if_id_o, flush_id_ex_o,
    input  halted_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i,
    input  hold_ex_i, hold_mem_i,
    input  halt_req_i, resume_req_i,
    output jump_en_o, jump_addr_o,
    output stall_pc_o, stall_if_id_o,
    output stall_id_ex_o,
    output flush_if_id_o, flush_id_ex_o,
    output halted_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: redirect/stall/flush arbiter for the IF-ID-EX pipe.
// Halt/resume FSM is built only with PIPE_CTRL_HALT_EN defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  logic        hold;
  logic        run_je;
  logic [31:0] run_ja;
  logic        run_stall;
  logic        run_flush;

  assign hold = bus.hold_mem_i | bus.hold_ex_i;

  // RUN priority: holds beat redirects, the jump is re-presented
  always_comb begin
    run_je    = 1'b0;
    run_ja    = '0;
    run_stall = 1'b0;
    run_flush = 1'b0;
    if (hold) begin
      run_stall = 1'b1;
    end else if (bus.jump_en_i) begin
      run_je    = 1'b1;
      run_ja    = bus.jump_addr_i;
      run_flush = 1'b1;
    end
  end

`ifdef PIPE_CTRL_HALT_EN
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        je, spc, sif, sie, fif, fie, hlt;
  logic [31:0] ja;

  // halt FSM state, drain counter and replayed redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CTRL_RUN;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // next state and per-state pipeline controls
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    je  = 1'b0;
    ja  = '0;
    spc = 1'b0;
    sif = 1'b0;
    sie = 1'b0;
    fif = 1'b0;
    fie = 1'b0;
    hlt = 1'b0;
    unique case (state_q)
      CTRL_RUN: begin
        je  = run_je;
        ja  = run_ja;
        spc = run_stall;
        sif = run_stall;
        sie = run_stall;
        fif = run_flush;
        fie = run_flush;
        if (bus.halt_req_i) begin
          state_d = CTRL_DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      CTRL_DRAIN: begin
        spc = 1'b1;
        fif = 1'b1;
        if (hold) begin
          sie = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (bus.jump_en_i) begin
            fie         = 1'b1;
            pend_vld_d  = 1'b1;
            pend_addr_d = bus.jump_addr_i;
          end
          if (cnt_q == 4'd1) begin
            state_d = CTRL_HALTED;
          end
        end
      end
      CTRL_HALTED: begin
        hlt = 1'b1;
        spc = 1'b1;
        fif = 1'b1;
        fie = 1'b1;
        if (bus.resume_req_i) begin
          state_d = CTRL_RESUME;
        end
      end
      CTRL_RESUME: begin
        if (pend_vld_q) begin
          je         = 1'b1;
          ja         = pend_addr_q;
          pend_vld_d = 1'b0;
        end
        state_d = CTRL_RUN;
      end
      default: state_d = CTRL_RUN;
    endcase
  end

  assign bus.jump_en_o     = je;
  assign bus.jump_addr_o   = ja;
  assign bus.stall_pc_o    = spc;
  assign bus.stall_if_id_o = sif;
  assign bus.stall_id_ex_o = sie;
  assign bus.flush_if_id_o = fif;
  assign bus.flush_id_ex_o = fie;
  assign bus.halted_o      = hlt;
`else
  logic unused_halt;
  assign unused_halt = &{1'b0, clk, rst_n,
                         bus.halt_req_i,
                         bus.resume_req_i};

  assign bus.jump_en_o     = run_je;
  assign bus.jump_addr_o   = run_ja;
  assign bus.stall_pc_o    = run_stall;
  assign bus.stall_if_id_o = run_stall;
  assign bus.stall_id_ex_o = run_stall;
  assign bus.flush_if_id_o = run_flush;
  assign bus.flush_id_ex_o = run_flush;
  assign bus.halted_o      = 1'b0;
`endif

endmodule
